// File: rtl/moore_input_conditioner.sv
// moore_input_conditioner
//   Input stage in front of a Moore FSM. Synchronises a raw push-button and a
//   raw data switch to inputClk, debounces the button, and for every accepted
//   press presents the synchronised data bit on outputX together with a
//   single-cycle outputStrobe that acts as the FSM advance enable.
//
// Ports
//   inputClk      in   1  single clock, all logic on posedge
//   inputR        in   1  synchronous active-high reset
//   inputBtn      in   1  raw asynchronous push-button (1 = pressed)
//   inputBit      in   1  raw asynchronous data switch
//   outputX       out  1  data bit captured at the last accepted press
//   outputStrobe  out  1  one-cycle pulse per accepted press
//   outputState   out  2  debug: 0 IDLE, 1 PRESS_WAIT, 2 PRESSED, 3 RELEASE_WAIT
//   outputCount   out  8  accepted-press count (only with PRESS_COUNT_EN)
//
// Configuration
//   PRESS_COUNT_EN  when defined, adds outputCount, an 8-bit wrapping count of
//                   accepted presses cleared by inputR.
module moore_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic       inputClk,
  input  logic       inputR,
  input  logic       inputBtn,
  input  logic       inputBit,
  output logic       outputX,
  output logic       outputStrobe,
  output logic [1:0] outputState
`ifdef PRESS_COUNT_EN
  ,
  output logic [7:0] outputCount
`endif
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } stateT;

  // Last debounce count value; reaching it on a stable cycle completes the wait.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       btnChainR;
  logic [1:0]       bitChainR;
  logic             btnSyncS;
  logic             bitSyncS;
  stateT            stateR;
  stateT            stateNextS;
  logic [CNT_W-1:0] cntR;
  logic [CNT_W-1:0] cntNextS;
  logic             xNextS;
  logic             strobeNextS;

  assign btnSyncS = btnChainR[1];
  assign bitSyncS = bitChainR[1];

  // Two-flop synchronisers for the raw button and data switch.
  always_ff @(posedge inputClk) begin
    if (inputR) begin
      btnChainR <= 2'b00;
      bitChainR <= 2'b00;
    end else begin
      btnChainR <= {btnChainR[0], inputBtn};
      bitChainR <= {bitChainR[0], inputBit};
    end
  end

  // Debounce FSM next-state, counter and output decode.
  always_comb begin
    stateNextS  = stateR;
    cntNextS    = cntR;
    xNextS      = outputX;
    strobeNextS = 1'b0;
    case (stateR)
      IDLE: begin
        if (btnSyncS) begin
          stateNextS = PRESS_WAIT;
          cntNextS   = {CNT_W{1'b0}};
        end else begin
          stateNextS = IDLE;
        end
      end
      PRESS_WAIT: begin
        if (!btnSyncS) begin
          // Bounce before the press was stable long enough: reject it.
          stateNextS = IDLE;
          cntNextS   = {CNT_W{1'b0}};
        end else if (cntR == CNT_LAST) begin
          stateNextS  = PRESSED;
          xNextS      = bitSyncS;
          strobeNextS = 1'b1;
        end else begin
          cntNextS = cntR + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btnSyncS) begin
          stateNextS = RELEASE_WAIT;
          cntNextS   = {CNT_W{1'b0}};
        end else begin
          stateNextS = PRESSED;
        end
      end
      RELEASE_WAIT: begin
        if (btnSyncS) begin
          // Release glitch: back to PRESSED without a new strobe.
          stateNextS = PRESSED;
        end else if (cntR == CNT_LAST) begin
          stateNextS = IDLE;
        end else begin
          cntNextS = cntR + CNT_W'(1);
        end
      end
      default: begin
        stateNextS = IDLE;
        cntNextS   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge inputClk) begin
    if (inputR) begin
      stateR       <= IDLE;
      cntR         <= {CNT_W{1'b0}};
      outputX      <= 1'b0;
      outputStrobe <= 1'b0;
    end else begin
      stateR       <= stateNextS;
      cntR         <= cntNextS;
      outputX      <= xNextS;
      outputStrobe <= strobeNextS;
    end
  end

  assign outputState = stateR;

`ifdef PRESS_COUNT_EN
  // Accepted-press counter, advancing on the edge that raises the strobe.
  always_ff @(posedge inputClk) begin
    if (inputR) begin
      outputCount <= 8'd0;
    end else if (strobeNextS) begin
      outputCount <= outputCount + 8'd1;
    end else begin
      outputCount <= outputCount;
    end
  end
`endif

endmodule
